// File: rtl/bcd_display_driver.sv
// rtl/bcd_display_driver.sv - double-dabble binary-to-BCD converter driving a 4-digit scanned display (option: LEADING_ZERO_BLANK_EN)
module bcd_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] bin_in,
    input  logic        load,
    output logic        busy,
    output logic        ovf,
    output logic [3:0]  BCD,
    output logic [3:0]  anode
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state, state_next;
    logic [15:0] acc;
    logic [15:0] acc_adj;
    logic [15:0] display;
    logic [13:0] bin;
    logic [3:0]  cnt;
    logic [PW-1:0] pre;
    logic [1:0]  idx;

    assign busy = (state != IDLE);

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (cnt == 4'd13) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= 16'd0;
            bin     <= 14'd0;
            cnt     <= 4'd0;
            ovf     <= 1'b0;
            display <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin <= (bin_in > 14'd9999) ? 14'd9999 : bin_in;
                        ovf <= (bin_in > 14'd9999);
                        acc <= 16'd0;
                        cnt <= 4'd0;
                    end
                end
                SHIFT: begin
                    // Top accumulator bit is always zero for inputs <= 9999.
                    {acc, bin} <= {acc_adj[14:0], bin, 1'b0};
                    cnt        <= cnt + 4'd1;
                end
                COMMIT:  display <= acc;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= 2'd0;
        end else if (pre == PRE_MAX) begin
            pre <= '0;
            idx <= idx + 2'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic blank;

    always_comb begin
        case (idx)
            2'd1:    blank = (display[15:4]  == 12'd0);
            2'd2:    blank = (display[15:8]  == 8'd0);
            2'd3:    blank = (display[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
    end

    always_comb begin
        BCD   = display[{idx, 2'b00} +: 4];
        anode = blank ? 4'b1111 : ~(4'b0001 << idx);
    end
`else
    always_comb begin
        BCD   = display[{idx, 2'b00} +: 4];
        anode = ~(4'b0001 << idx);
    end
`endif

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb/tb_bcd_display_driver.sv - table-driven scoreboard bench for bcd_display_driver
module tb_bcd_display_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [13:0] bin_in;
    logic        busy;
    logic        ovf;
    logic [3:0]  BCD;
    logic [3:0]  anode;

    bcd_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .bin_in (bin_in),
        .load   (load),
        .busy   (busy),
        .ovf    (ovf),
        .BCD    (BCD),
        .anode  (anode)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // Reference scan position: REFRESH_DIV cycles per digit, counted from reset.
    int       m_pre;
    logic [1:0] m_idx;
    always @(posedge clk) begin
        if (rst) begin
            m_pre <= 0;
            m_idx <= 2'd0;
        end else if (m_pre == DIV - 1) begin
            m_pre <= 0;
            m_idx <= m_idx + 2'd1;
        end else begin
            m_pre <= m_pre + 1;
        end
    end

    typedef struct {
        logic [13:0] bin;
        logic [15:0] disp;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] disp;
        logic        ovf;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_load(input logic [13:0] b);
        @(negedge clk);
        load   = 1'b1;
        bin_in = b;
        @(posedge clk);
        #1;
        load   = 1'b0;
        bin_in = 14'($urandom);
    endtask

    task automatic wait_busy(input int inj_at, input logic [13:0] inj_bin, output int cnt);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) begin
                load = 1'b0;
                break;
            end
            cnt++;
            if (cnt == inj_at) begin
                load   = 1'b1;
                bin_in = inj_bin;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic scan_check(input string name, input logic [15:0] exp_disp);
        logic [15:0] got;
        logic [3:0]  exp_an;
        int          bad;
        got = 16'd0;
        bad = 0;
        for (int k = 0; k < 4 * DIV; k++) begin
            @(negedge clk);
            got[{m_idx, 2'b00} +: 4] = BCD;
            exp_an = ~(4'b0001 << m_idx);
`ifdef LEADING_ZERO_BLANK_EN
            if (m_idx != 2'd0 && (exp_disp >> (4 * m_idx)) == 16'd0) exp_an = 4'b1111;
`endif
            if (anode !== exp_an) bad++;
        end
        check({name, " display"}, got, exp_disp);
        check({name, " anode scan errors"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   cnt;
        exp_t e;
        int   hi;

        vecs[0] = '{14'd1234,  16'h1234, 1'b0};
        vecs[1] = '{14'd12000, 16'h9999, 1'b1};
        vecs[2] = '{14'd5,     16'h0005, 1'b0};
        vecs[3] = '{14'd9999,  16'h9999, 1'b0};
        vecs[4] = '{14'd10000, 16'h9999, 1'b1};
        vecs[5] = '{14'd7,     16'h0007, 1'b0};
        vecs[6] = '{14'd0,     16'h0000, 1'b0};
        vecs[7] = '{14'd16383, 16'h9999, 1'b1};
        vecs[8] = '{14'd9090,  16'h9090, 1'b0};

        rst    = 1'b1;
        load   = 1'b0;
        bin_in = 14'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset anode", anode, 4'b1110);
        check("reset BCD", BCD, 4'h0);
        check("reset busy", busy, 1'b0);
        check("reset ovf", ovf, 1'b0);
        repeat (DIV - 1) @(negedge clk);
        check("anode before first wrap", anode, 4'b1110);
        @(negedge clk);
        check("anode after first wrap", anode, 4'b1101);

        for (int v = 0; v < 9; v++) begin
            do_load(vecs[v].bin);
            sbq.push_back('{vecs[v].disp, vecs[v].ovf});
            wait_busy(0, 14'd0, cnt);
            check($sformatf("vec%0d busy length", v), cnt, 15);
            e = sbq.pop_front();
            check($sformatf("vec%0d ovf", v), ovf, e.ovf);
            scan_check($sformatf("vec%0d", v), e.disp);
        end

        // Load during busy is dropped and the captured value is kept.
        do_load(14'd42);
        sbq.push_back('{16'h0042, 1'b0});
        wait_busy(5, 14'd77, cnt);
        check("busy load busy length", cnt, 15);
        e = sbq.pop_front();
        check("busy load ovf", ovf, e.ovf);
        scan_check("busy load", e.disp);
        check("busy load no restart", busy, 1'b0);

        // Load during COMMIT is ignored.
        do_load(14'd600);
        sbq.push_back('{16'h0600, 1'b0});
        wait_busy(15, 14'd12000, cnt);
        check("commit load busy length", cnt, 15);
        @(negedge clk);
        check("commit load ignored busy", busy, 1'b0);
        e = sbq.pop_front();
        check("commit load ovf", ovf, e.ovf);
        scan_check("commit load", e.disp);

        // Reset mid-conversion aborts and beats a simultaneous load.
        do_load(14'd9999);
        cnt = 0;
        for (int k = 0; k < 40 && cnt < 8; k++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("abort reached 8th shift", cnt, 8);
        rst    = 1'b1;
        load   = 1'b1;
        bin_in = 14'd12000;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort ovf", ovf, 1'b0);
        check("abort anode", anode, 4'b1110);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) hi++;
        end
        check("abort busy stays low", hi, 0);
        scan_check("abort", 16'h0000);

        check("scoreboard drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clock cycles each digit stays lit; legal range 2..2^20.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: bin_in  input  14  unsigned binary value to display.
REQ-005 Port: load  input  1  request strobe; bin_in sampled in the same cycle.
REQ-006 Port: busy  output  1  conversion in progress; load ignored while high.
REQ-007 Port: ovf  output  1  high when the last accepted bin_in exceeded 9999.
REQ-008 Port: BCD  output  4  BCD digit for the currently scanned position; drives the downstream BCD-to-7-segment decoder.
REQ-009 Port: anode  output  4  active-low digit enables; bit n selects digit n (digit 0 is the least significant).

Function
REQ-010 The FSM SHALL use states IDLE, SHIFT and COMMIT.
REQ-011 In IDLE with load=1, the block SHALL capture min(bin_in, 9999), set ovf to (bin_in>9999), clear the 16-bit BCD accumulator and shift counter, and enter SHIFT.
REQ-012 Each SHIFT cycle SHALL first add 3 to every accumulator nibble >=5, then shift {accumulator, binary} left by one bit.
REQ-013 After the 14th shift, the FSM SHALL enter COMMIT, copy the accumulator into the display register, then return to IDLE.
REQ-014 busy SHALL be high for exactly 15 cycles, beginning the cycle after load is accepted; the display register SHALL be updated on the edge that ends COMMIT.
REQ-015 load asserted while busy=1 SHALL be dropped: it is not queued, and bin_in, ovf and the conversion are unaffected.
REQ-016 load asserted in the same cycle that COMMIT returns the FSM to IDLE SHALL be ignored; it is accepted only when the state is IDLE.
REQ-017 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap continuously, independent of the FSM.
REQ-018 On each prescaler wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-019 anode SHALL equal the active-low one-hot of the digit index; BCD SHALL equal display-register nibble [4*index+3:4*index].
REQ-020 BCD and anode SHALL be combinational from the digit index and display register, so a COMMIT takes effect on the currently lit digit without waiting for the next scan step.
REQ-021 The display register SHALL hold its value until the next COMMIT; the previous value stays displayed throughout a conversion.

Reset
REQ-022 With rst=1 at a clock edge, the block SHALL set: state IDLE, busy=0, ovf=0, display register 0, accumulator 0, prescaler 0, digit index 0, anode=4'b1110, BCD=4'h0.
REQ-023 rst asserted mid-conversion SHALL abort the conversion with no COMMIT, and SHALL take priority over load in the same cycle.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN defined: when the scanned digit n>0 and display nibbles n..3 are all zero, anode SHALL be 4'b1111 for that scan slot; digit 0 SHALL never be blanked; scan timing SHALL be unchanged.
REQ-025 Macro LEADING_ZERO_BLANK_EN undefined: all four digits SHALL always be enabled in turn, and no blanking logic SHALL be synthesised.

Verification
REQ-026 rst high for 2 cycles, then low -> anode=1110, BCD=0, busy=0, ovf=0; index advances to 1 (anode=1101) after REFRESH_DIV cycles.
REQ-027 load with bin_in=1234 -> busy high for 15 cycles; display register then 16'h1234; scanning outputs BCD 4,3,2,1 with anode 1110, 1101, 1011, 0111.
REQ-028 load with bin_in=12000 -> ovf=1, display 16'h9999; a following load of 5 -> ovf=0, display 16'h0005.
REQ-029 load 42, then load 77 on the 5th busy cycle -> second load ignored; display 16'h0042 and busy falls after exactly 15 cycles.
REQ-030 rst pulsed on the 8th SHIFT cycle of a conversion of 9999 -> display stays 0, busy=0, state IDLE.
REQ-031 With LEADING_ZERO_BLANK_EN defined, load 7 -> anode=1111 during scan slots 1..3; slot 0 shows BCD=7 with anode=1110; load 0 -> slot 0 shows BCD=0.
